// File: rtl/dsp_mult_share_arbiter.sv
// Shares one 20x18 DSP multiplier among NREQ valid/ready requesters; results return with id via a FIFO.
// Optional DSP_MULT_ARB_RR_EN selects round-robin arbitration (default: fixed priority, index 0 highest).
module dsp_mult_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 4,
  parameter int DSP_REGIN = 0
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*20-1:0]        req_a_i,
  input  logic [NREQ*18-1:0]        req_b_i,
  input  logic [NREQ-1:0]           req_unsigned_a_i,
  input  logic [NREQ-1:0]           req_unsigned_b_i,
  output logic [19:0]               dsp_a_o,
  output logic [17:0]               dsp_b_o,
  output logic                      dsp_unsigned_a_o,
  output logic                      dsp_unsigned_b_o,
  output logic [2:0]                dsp_feedback_o,
  output logic                      dsp_register_inputs_o,
  output logic [2:0]                dsp_output_select_o,
  input  logic [37:0]               dsp_z_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [37:0]               rsp_z_o,
  output logic [$clog2(NREQ)-1:0]   rsp_id_o,
  output logic                      busy_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic            r_run;
  logic [CW-1:0]   r_credits;
  logic            w_can_accept;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_found;
  logic            w_accept;
  logic            w_push;
  logic [IDW-1:0]  w_push_id;
  logic            w_pop;

  logic [19:0]     r_a;
  logic [17:0]     r_b;
  logic            r_ua;
  logic            r_ub;
  logic            r_v0;
  logic [IDW-1:0]  r_id0;

  logic [37:0]     r_mem_z  [DEPTH];
  logic [IDW-1:0]  r_mem_id [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // r_run keeps req_ready_o low while reset is asserted and for the release cycle
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  assign w_can_accept = r_run && (r_credits < CW'(DEPTH));

`ifdef DSP_MULT_ARB_RR_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_scan_id;

  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_found   = 1'b0;
    w_scan_id = '0;
    if (w_can_accept) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        w_scan_id = IDW'((32'(r_ptr) + i) % NREQ);
        if (!w_found && req_valid_i[w_scan_id]) begin
          w_found             = 1'b1;
          w_grant[w_scan_id]  = 1'b1;
          w_gnt_id            = w_scan_id;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)    r_ptr <= '0;
    else if (w_accept) r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
  end
`else
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    if (w_can_accept) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid_i[IDW'(i)]) begin
          w_found             = 1'b1;
          w_grant[IDW'(i)]    = 1'b1;
          w_gnt_id            = IDW'(i);
        end
      end
    end
  end
`endif

  assign w_accept    = |w_grant;
  assign req_ready_o = w_grant;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ua  <= 1'b0;
      r_ub  <= 1'b0;
      r_v0  <= 1'b0;
      r_id0 <= '0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_a   <= req_a_i[w_gnt_id*20 +: 20];
        r_b   <= req_b_i[w_gnt_id*18 +: 18];
        r_ua  <= req_unsigned_a_i[w_gnt_id];
        r_ub  <= req_unsigned_b_i[w_gnt_id];
        r_id0 <= w_gnt_id;
      end
    end
  end

  assign dsp_a_o               = r_a;
  assign dsp_b_o               = r_b;
  assign dsp_unsigned_a_o      = r_ua;
  assign dsp_unsigned_b_o      = r_ub;
  assign dsp_feedback_o        = 3'h0;
  assign dsp_register_inputs_o = (DSP_REGIN != 0);
  assign dsp_output_select_o   = 3'h0;

  // With DSP input registers enabled the product appears one cycle later, so the tag is delayed to match
  generate
    if (DSP_REGIN != 0) begin : g_regin
      logic           r_v1;
      logic [IDW-1:0] r_id1;
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_v1  <= 1'b0;
          r_id1 <= '0;
        end else begin
          r_v1  <= r_v0;
          r_id1 <= r_id0;
        end
      end
      assign w_push    = r_v1;
      assign w_push_id = r_id1;
    end else begin : g_noregin
      assign w_push    = r_v0;
      assign w_push_id = r_id0;
    end
  endgenerate

  assign rsp_valid_o = (r_count != '0);
  assign w_pop       = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_z[AW'(i)]  <= '0;
        r_mem_id[AW'(i)] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_z[r_wptr]  <= dsp_z_i;
        r_mem_id[r_wptr] <= w_push_id;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Credits cover in-flight products plus FIFO occupancy, so a push never meets a full FIFO
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_credits <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_z_o  = r_mem_z[r_rptr];
  assign rsp_id_o = r_mem_id[r_rptr];
  assign busy_o   = (r_credits != '0);

endmodule

// File: tb/tb_dsp_mult_share_arbiter.sv
// Bench for dsp_mult_share_arbiter: behavioural DSP model, scoreboard of expected products, per-scenario tasks.
module tb_dsp_mult_share_arbiter;

  logic          clk;
  logic          reset_n_i;
  logic [3:0]    req_valid_i;
  logic [3:0]    req_ready_o;
  logic [79:0]   req_a_i;
  logic [71:0]   req_b_i;
  logic [3:0]    req_unsigned_a_i;
  logic [3:0]    req_unsigned_b_i;
  logic [19:0]   dsp_a_o;
  logic [17:0]   dsp_b_o;
  logic          dsp_unsigned_a_o;
  logic          dsp_unsigned_b_o;
  logic [2:0]    dsp_feedback_o;
  logic          dsp_register_inputs_o;
  logic [2:0]    dsp_output_select_o;
  logic [37:0]   dsp_z_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [37:0]   rsp_z_o;
  logic [1:0]    rsp_id_o;
  logic          busy_o;

  typedef struct packed {
    logic [37:0] z;
    logic [1:0]  id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  dsp_mult_share_arbiter #(.NREQ(4), .DEPTH(4), .DSP_REGIN(0)) u_dut (
    .clock_i               (clk),
    .reset_n_i             (reset_n_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_a_i               (req_a_i),
    .req_b_i               (req_b_i),
    .req_unsigned_a_i      (req_unsigned_a_i),
    .req_unsigned_b_i      (req_unsigned_b_i),
    .dsp_a_o               (dsp_a_o),
    .dsp_b_o               (dsp_b_o),
    .dsp_unsigned_a_o      (dsp_unsigned_a_o),
    .dsp_unsigned_b_o      (dsp_unsigned_b_o),
    .dsp_feedback_o        (dsp_feedback_o),
    .dsp_register_inputs_o (dsp_register_inputs_o),
    .dsp_output_select_o   (dsp_output_select_o),
    .dsp_z_i               (dsp_z_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_ready_i           (rsp_ready_i),
    .rsp_z_o               (rsp_z_o),
    .rsp_id_o              (rsp_id_o),
    .busy_o                (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP model: 21x19 signed multiply of the flag-extended operands, optional input register
  logic signed [39:0] w_prod;
  logic        [39:0] r_prod;
  always_comb w_prod = $signed({dsp_a_o[19] & ~dsp_unsigned_a_o, dsp_a_o}) *
                       $signed({dsp_b_o[17] & ~dsp_unsigned_b_o, dsp_b_o});
  always_ff @(posedge clk) r_prod <= w_prod;
  assign dsp_z_i = dsp_register_inputs_o ? r_prod[37:0] : w_prod[37:0];

  function automatic logic [37:0] exp_prod(input logic [19:0] a, input logic [17:0] b,
                                           input logic ua, input logic ub);
    longint      sa, sb;
    logic [63:0] p;
    sa = ua ? longint'({44'd0, a}) : longint'({{44{a[19]}}, a});
    sb = ub ? longint'({46'd0, b}) : longint'({{46{b[17]}}, b});
    p  = sa * sb;
    return p[37:0];
  endfunction

  // Scoreboard: pop and compare on every response handshake, push on every request handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset_n_i) begin
      if (rsp_valid_o && rsp_ready_i) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_rsp: got z=%h id=%0d, required no response", rsp_z_o, rsp_id_o);
        end else begin
          e = sb_q.pop_front();
          if (rsp_z_o !== e.z || rsp_id_o !== e.id) begin
            n_fail++;
            $display("FAIL sb_rsp: got z=%h id=%0d, required z=%h id=%0d", rsp_z_o, rsp_id_o, e.z, e.id);
          end
        end
      end
      n_cmp++;
      if ($countones(req_ready_o) > 1) begin
        n_fail++;
        $display("FAIL ready_onehot: got %b, required at most one bit", req_ready_o);
      end
      for (int k = 0; k < 4; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          e.z  = exp_prod(req_a_i[k*20 +: 20], req_b_i[k*18 +: 18], req_unsigned_a_i[k], req_unsigned_b_i[k]);
          e.id = 2'(k);
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic drive_req(input int k, input logic [19:0] a, input logic [17:0] b,
                           input logic ua, input logic ub);
    req_a_i[k*20 +: 20]  = a;
    req_b_i[k*18 +: 18]  = b;
    req_unsigned_a_i[k]  = ua;
    req_unsigned_b_i[k]  = ub;
  endtask

  task automatic drive_rand(input int k);
    drive_req(k, 20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    reset_n_i   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    sb_q.delete();
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!busy_o) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: busy_o still %b, required 0 within 30 cycles", busy_o);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_sb_empty: got %0d outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic wait_ready(input int k, output bit seen);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (req_ready_o[k]) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ready_timeout_req%0d: req_ready_o=%b, required bit %0d set", k, req_ready_o, k);
    end
  endtask

  task automatic test_reset();
    reset_n_i   = 1'b0;
    req_valid_i = '1;
    rsp_ready_i = 1'b0;
    req_a_i = '0; req_b_i = '0; req_unsigned_a_i = '0; req_unsigned_b_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready_o); end
    n_cmp++; if (dsp_a_o !== 20'd0) begin n_fail++; $display("FAIL reset_dsp_a: got %h, required 0", dsp_a_o); end
    n_cmp++; if (dsp_b_o !== 18'd0) begin n_fail++; $display("FAIL reset_dsp_b: got %h, required 0", dsp_b_o); end
    n_cmp++; if ({dsp_unsigned_a_o, dsp_unsigned_b_o} !== 2'b00) begin n_fail++; $display("FAIL reset_unsigned: got %b%b, required 00", dsp_unsigned_a_o, dsp_unsigned_b_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid_o); end
    n_cmp++; if (rsp_z_o !== 38'd0) begin n_fail++; $display("FAIL reset_rsp_z: got %h, required 0", rsp_z_o); end
    n_cmp++; if (rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    n_cmp++; if ({dsp_feedback_o, dsp_register_inputs_o, dsp_output_select_o} !== 7'd0) begin
      n_fail++; $display("FAIL cfg_ports: got fb=%h ri=%b os=%h, required 0/0/0", dsp_feedback_o, dsp_register_inputs_o, dsp_output_select_o);
    end
    req_valid_i = '0;
    @(posedge clk); #2;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string nm, input int k, input logic [19:0] a, input logic [17:0] b,
                             input logic ua, input logic ub, input logic [37:0] z_req);
    bit seen;
    rsp_ready_i = 1'b1;
    drive_req(k, a, b, ua, ub);
    req_valid_i = 4'b0001 << k;
    wait_ready(k, seen);
    @(posedge clk);
    #1;
    req_valid_i = '0;
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_early: rsp_valid_o=%b one cycle after accept, required 0", nm, rsp_valid_o); end
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_latency: rsp_valid_o=%b two cycles after accept, required 1", nm, rsp_valid_o); end
    n_cmp++; if (rsp_z_o !== z_req || rsp_id_o !== 2'(k)) begin
      n_fail++; $display("FAIL %s_value: got z=%h id=%0d, required z=%h id=%0d", nm, rsp_z_o, rsp_id_o, z_req, k);
    end
    drain();
  endtask

  task automatic test_rr_order();
    logic [3:0] exp_g;
    do_reset();
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) drive_rand(k);
    req_valid_i = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (c % 4);
      n_cmp++;
      if (req_ready_o !== exp_g) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b, required %b", c, req_ready_o, exp_g);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) drive_rand(k);
    end
    drain();
  endtask

  task automatic test_fixed_priority();
    rsp_ready_i = 1'b1;
    drive_rand(0);
    drive_rand(1);
    req_valid_i = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL fixed_prio_%0d: got %b, required 0001", c, req_ready_o); end
      @(posedge clk); #1;
      drive_rand(0);
    end
    req_valid_i[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL fixed_prio_req1: got %b, required 0010", req_ready_o); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int acc;
    bit seen;
    acc = 0;
    rsp_ready_i = 1'b0;
    drive_rand(1);
    req_valid_i = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid_i[1] && req_ready_o[1]) acc++;
      @(posedge clk); #1;
      drive_rand(1);
    end
    n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d, required 4", acc); end
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b, required 0000", req_ready_o); end
    n_cmp++; if (busy_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_status: got busy=%b valid=%b, required 1/1", busy_o, rsp_valid_o);
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL bp_head: got empty scoreboard, required 4 entries");
    end else if (rsp_z_o !== sb_q[0].z || rsp_id_o !== sb_q[0].id) begin
      n_fail++; $display("FAIL bp_head: got z=%h id=%0d, required z=%h id=%0d", rsp_z_o, rsp_id_o, sb_q[0].z, sb_q[0].id);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    wait_ready(1, seen);
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    rsp_ready_i = 1'b0;
    drive_rand(0);
    req_valid_i = 4'b0001;
    repeat (3) @(posedge clk);
    #2;
    req_valid_i = '0;
    reset_n_i   = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy_o); end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n_i   = 1'b1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid_o) stale++;
    end
    n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale cycles, required 0", stale); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      req_valid_i = 4'($urandom);
      for (int k = 0; k < 4; k++) drive_rand(k);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single("signed", 0, 20'sd3, -18'sd5, 1'b0, 1'b0, 38'h3F_FFFF_FFF1);
    test_single("unsigned", 2, 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 38'h3F_FFEC_0001);
`ifdef DSP_MULT_ARB_RR_EN
    test_rr_order();
`else
    test_fixed_priority();
`endif
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
